// File: rtl/bankgroup_cmd_ctrl.sv
// Bank-group command controller: per-bank ACT/PRE timing, RD/WR burst
// sequencing onto the bundled bank interface, and fixed-latency read return.
module bankgroup_cmd_ctrl #(
  parameter int unsigned BAWIDTH       = 2,
  parameter int unsigned BANKSPERGROUP = 2**BAWIDTH,
  parameter int unsigned COLWIDTH      = 10,
  parameter int unsigned DEVICE_WIDTH  = 4,
  parameter int unsigned CHWIDTH       = 5,
  parameter int unsigned BL            = 4,
  parameter int unsigned TRCD          = 3,
  parameter int unsigned TRP           = 3,
  parameter int unsigned TCL           = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd,
  input  logic [BAWIDTH-1:0]      cmd_ba,
  input  logic [CHWIDTH-1:0]      cmd_row,
  input  logic [COLWIDTH-1:0]     cmd_col,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  output logic                    wdata_req,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    rdata_valid,
  output logic                    cmd_err,
  output logic [BANKSPERGROUP-1:0] bank_open,
  output logic [0:0]              bank_rd_o_wr [BANKSPERGROUP],
  output logic [DEVICE_WIDTH-1:0] bank_dqin    [BANKSPERGROUP],
  input  logic [DEVICE_WIDTH-1:0] bank_dqout   [BANKSPERGROUP],
  output logic [CHWIDTH-1:0]      bank_row     [BANKSPERGROUP],
  output logic [COLWIDTH-1:0]     bank_column  [BANKSPERGROUP]
);

  localparam int unsigned TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned CNTW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned BLW  = (BL > 1) ? $clog2(BL) : 1;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ACTIVATING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE      = 2'd2;
  localparam logic [1:0] ST_PRECHARGING = 2'd3;

  logic [1:0]         r_state     [BANKSPERGROUP];
  logic [CNTW-1:0]    r_cnt       [BANKSPERGROUP];
  logic [1:0]         w_state_nxt [BANKSPERGROUP];
  logic [CNTW-1:0]    w_cnt_nxt   [BANKSPERGROUP];
  logic [BANKSPERGROUP-1:0] r_open;
  logic [CHWIDTH-1:0]  r_row [BANKSPERGROUP];
  logic [COLWIDTH-1:0] r_col [BANKSPERGROUP];

  logic               r_burst_active;
  logic               r_burst_wr;
  logic [BAWIDTH-1:0] r_burst_ba;
  logic [BLW-1:0]     r_beat;
  logic               r_err;
  logic               r_cap_v;
  logic [BAWIDTH-1:0] r_cap_ba;

  logic [1:0]              w_cur_state;
  logic                    w_legal;
  logic                    w_acc;
  logic                    w_do_cmd;
  logic                    w_burst_start;
  logic [DEVICE_WIDTH-1:0] w_cap_data;

  assign cmd_ready     = ~r_burst_active;
  assign w_acc         = cmd_valid & cmd_ready;
  assign w_do_cmd      = w_acc & w_legal;
  assign w_burst_start = w_do_cmd & ((cmd == CMD_RD) || (cmd == CMD_WR));

  // Legality is judged against the addressed bank's current state
  always_comb begin
    w_cur_state = r_state[cmd_ba];
    w_legal     = 1'b0;
    case (cmd)
      CMD_ACT:        w_legal = (w_cur_state == ST_IDLE);
      CMD_RD, CMD_WR: w_legal = (w_cur_state == ST_ACTIVE);
      default:        w_legal = (w_cur_state == ST_ACTIVE) || (w_cur_state == ST_IDLE);
    endcase
  end

  // Per-bank next state; timers hold remaining cycles and leave at 1
  always_comb begin
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      w_state_nxt[b] = r_state[b];
      w_cnt_nxt[b]   = r_cnt[b];
      case (r_state[b])
        ST_IDLE: begin
          if (w_do_cmd && (cmd == CMD_ACT) && (cmd_ba == BAWIDTH'(b))) begin
            if (TRCD == 1) begin
              w_state_nxt[b] = ST_ACTIVE;
            end else begin
              w_state_nxt[b] = ST_ACTIVATING;
              w_cnt_nxt[b]   = CNTW'(TRCD - 1);
            end
          end
        end
        ST_ACTIVATING: begin
          if (r_cnt[b] <= CNTW'(1)) w_state_nxt[b] = ST_ACTIVE;
          else                      w_cnt_nxt[b]   = r_cnt[b] - CNTW'(1);
        end
        ST_ACTIVE: begin
          if (w_do_cmd && (cmd == CMD_PRE) && (cmd_ba == BAWIDTH'(b))) begin
            if (TRP == 1) begin
              w_state_nxt[b] = ST_IDLE;
            end else begin
              w_state_nxt[b] = ST_PRECHARGING;
              w_cnt_nxt[b]   = CNTW'(TRP - 1);
            end
          end
        end
        default: begin
          if (r_cnt[b] <= CNTW'(1)) w_state_nxt[b] = ST_IDLE;
          else                      w_cnt_nxt[b]   = r_cnt[b] - CNTW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        r_state[b] <= ST_IDLE;
        r_cnt[b]   <= '0;
      end
      r_open <= '0;
    end else begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_cnt[b]   <= w_cnt_nxt[b];
        r_open[b]  <= (w_state_nxt[b] == ST_ACTIVE);
      end
    end
  end

  // Burst sequencer, row latches and per-bank column registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_active <= 1'b0;
      r_burst_wr     <= 1'b0;
      r_burst_ba     <= '0;
      r_beat         <= '0;
      r_err          <= 1'b0;
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        r_row[b] <= '0;
        r_col[b] <= '0;
      end
    end else begin
      r_err <= w_acc & ~w_legal;
      if (w_do_cmd && (cmd == CMD_ACT)) r_row[cmd_ba] <= cmd_row;
      if (w_burst_start) begin
        r_burst_active <= 1'b1;
        r_burst_wr     <= (cmd == CMD_WR);
        r_burst_ba     <= cmd_ba;
        r_beat         <= '0;
        r_col[cmd_ba]  <= cmd_col;
      end else if (r_burst_active) begin
        if (r_beat == BLW'(BL - 1)) begin
          r_burst_active <= 1'b0;
        end else begin
          r_beat            <= r_beat + BLW'(1);
          r_col[r_burst_ba] <= r_col[r_burst_ba] + COLWIDTH'(1);
        end
      end
    end
  end

  assign wdata_req = r_burst_active & r_burst_wr;
  assign cmd_err   = r_err;
  assign bank_open = r_open;

  always_comb begin
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      bank_rd_o_wr[b] = 1'(wdata_req && (r_burst_ba == BAWIDTH'(b)));
      bank_dqin[b]    = (wdata_req && (r_burst_ba == BAWIDTH'(b))) ? wdata : '0;
      bank_row[b]     = r_row[b];
      bank_column[b]  = r_col[b];
    end
  end

  // Bank data is valid the cycle after its read beat; remember where to pick it up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_v  <= 1'b0;
      r_cap_ba <= '0;
    end else begin
      r_cap_v  <= r_burst_active & ~r_burst_wr;
      r_cap_ba <= r_burst_ba;
    end
  end

  assign w_cap_data = r_cap_v ? bank_dqout[r_cap_ba] : '0;

  generate
    if (TCL == 1) begin : g_no_pipe
      assign rdata_valid = r_cap_v;
      assign rdata       = w_cap_data;
    end else begin : g_pipe
      logic                    r_pv [TCL-1];
      logic [DEVICE_WIDTH-1:0] r_pd [TCL-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < TCL - 1; i++) begin
            r_pv[i] <= 1'b0;
            r_pd[i] <= '0;
          end
        end else begin
          r_pv[0] <= r_cap_v;
          r_pd[0] <= w_cap_data;
          for (int i = 1; i < TCL - 1; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign rdata_valid = r_pv[TCL-2];
      assign rdata       = r_pd[TCL-2];
    end
  endgenerate

endmodule
